// File: rtl/md_init_scatter_if.sv
// Host-to-kernel AXI-Stream bundle used by the init scatter path.
//   tdata  : packed particle records
//   tkeep  : byte enables
//   tvalid : beat valid
//   tlast  : last beat of the init transfer
//   tdest  : destination cell index
//   tready : sink can accept the beat
// master drives the beat fields; slave drives tready.
interface md_init_scatter_if #(
   parameter int unsigned AXIS_TDATA_WIDTH      = 512,
   parameter int unsigned STREAMING_TDEST_WIDTH = 16
);
   logic [AXIS_TDATA_WIDTH-1:0]      tdata;
   logic [AXIS_TDATA_WIDTH/8-1:0]    tkeep;
   logic                             tvalid;
   logic                             tlast;
   logic [STREAMING_TDEST_WIDTH-1:0] tdest;
   logic                             tready;

   modport master (
      output tdata, tkeep, tvalid, tlast, tdest,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tdest,
      output tready
   );
endinterface

// File: rtl/md_init_scatter.sv
// Init scatter: accepts h2k beats of packed particle records, unpacks one record
// slot per cycle and writes each present record into the position cache chosen by tdest.
// Record layout: [96]=valid, [95:64]=z, [63:32]=y, [31:0]=x.
// Ports:
//   ap_clk, ap_rst   clock, async active-high reset
//   i_init_en        level, high while the MD state is INIT
//   S_AXIS_h2k       h2k stream (slave modport)
//   o_cell_wr_en     one-hot cache write strobe (registered)
//   o_cell_wr_data   position {z,y,x} (registered)
//   i_cell_ready     per-cache can-accept flag
//   o_rec_count      records written since i_init_en rose (saturating)
//   o_init_done      one-cycle pulse after the tlast beat has drained
//   o_bad_dest       sticky: a beat with tdest >= N_CELL was dropped
module md_init_scatter #(
   parameter int unsigned AXIS_TDATA_WIDTH      = 512,
   parameter int unsigned STREAMING_TDEST_WIDTH = 16,
   parameter int unsigned REC_WIDTH             = 97,
   parameter int unsigned N_SLOT                = 5,
   parameter int unsigned N_CELL                = 27
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic                     i_init_en,
   md_init_scatter_if.slave         S_AXIS_h2k,
   output logic [N_CELL-1:0]        o_cell_wr_en,
   output logic [REC_WIDTH-2:0]     o_cell_wr_data,
   input  logic [N_CELL-1:0]        i_cell_ready,
   output logic [31:0]              o_rec_count,
   output logic                     o_init_done,
   output logic                     o_bad_dest
);

   localparam int unsigned PosW  = REC_WIDTH - 1;
   localparam int unsigned SlotW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
   localparam int unsigned CellW = (N_CELL > 1) ? $clog2(N_CELL) : 1;
   localparam int unsigned DataW = REC_WIDTH * N_SLOT;

   typedef enum logic [1:0] {StIdle, StUnpack, StDone} state_e;

   state_e                          state_q, state_d;
   logic [SlotW-1:0]                slot_q, slot_d;
   logic [N_SLOT-1:0][PosW-1:0]     pos_q;
   logic [N_SLOT-1:0]               present_q;
   logic [CellW-1:0]                dest_q;
   logic                            last_q;
   logic [N_CELL-1:0]               wr_en_q, wr_en_d;
   logic [PosW-1:0]                 wr_data_q, wr_data_d;
   logic [31:0]                     count_q, count_d;
   logic                            done_q, done_d;
   logic                            bad_q, bad_d;
   logic                            init_en_q;

   logic [N_SLOT-1:0][PosW-1:0]     beat_pos;
   logic [N_SLOT-1:0]               beat_present;
   logic                            hs, dest_ok, load, init_rise, adv;

   // Upper data bits and non-valid-byte keep bits carry no information here.
   logic unused_in;
   assign unused_in = ^{S_AXIS_h2k.tkeep, S_AXIS_h2k.tdata[AXIS_TDATA_WIDTH-1:DataW]};

   assign S_AXIS_h2k.tready = (state_q == StIdle) && i_init_en;
   assign hs        = S_AXIS_h2k.tready && S_AXIS_h2k.tvalid;
   assign dest_ok   = S_AXIS_h2k.tdest < STREAMING_TDEST_WIDTH'(N_CELL);
   assign load      = hs && dest_ok;
   assign init_rise = i_init_en && !init_en_q;

   // Slot presence needs both the record valid bit and the keep bit of the byte holding it.
   always_comb begin
      for (int k = 0; k < N_SLOT; k++) begin
         beat_pos[k]     = S_AXIS_h2k.tdata[REC_WIDTH*k +: PosW];
         beat_present[k] = S_AXIS_h2k.tdata[REC_WIDTH*k + PosW]
                         & S_AXIS_h2k.tkeep[(REC_WIDTH*k + PosW) / 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      wr_en_d   = '0;
      wr_data_d = wr_data_q;
      count_d   = count_q;
      done_d    = 1'b0;
      bad_d     = bad_q;
      adv       = 1'b0;

      if (init_rise) begin
         count_d = '0;
         bad_d   = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (hs) begin
               if (dest_ok) begin
                  slot_d  = '0;
                  state_d = StUnpack;
               end else begin
                  bad_d   = 1'b1;
                  state_d = S_AXIS_h2k.tlast ? StDone : StIdle;
               end
            end
         end
         StUnpack: begin
            if (!i_init_en) begin
               state_d = StIdle;
            end else if (present_q[slot_q]) begin
               // Stall on a full cache without advancing the slot.
               if (i_cell_ready[dest_q]) begin
                  wr_en_d   = N_CELL'(1) << dest_q;
                  wr_data_d = pos_q[slot_q];
                  if (count_q != '1) count_d = count_q + 32'd1;
                  adv       = 1'b1;
               end
            end else begin
               adv = 1'b1;
            end
            if (adv) begin
               if (slot_q == SlotW'(N_SLOT - 1)) begin
                  slot_d  = '0;
                  state_d = last_q ? StDone : StIdle;
               end else begin
                  slot_d = slot_q + SlotW'(1);
               end
            end
         end
         StDone: begin
            done_d  = i_init_en;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q   <= StIdle;
         slot_q    <= '0;
         pos_q     <= '0;
         present_q <= '0;
         dest_q    <= '0;
         last_q    <= 1'b0;
         wr_en_q   <= '0;
         wr_data_q <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         bad_q     <= 1'b0;
         init_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         count_q   <= count_d;
         done_q    <= done_d;
         bad_q     <= bad_d;
         init_en_q <= i_init_en;
         if (load) begin
            pos_q     <= beat_pos;
            present_q <= beat_present;
            dest_q    <= CellW'(S_AXIS_h2k.tdest);
            last_q    <= S_AXIS_h2k.tlast;
         end else if (hs) begin
            last_q    <= S_AXIS_h2k.tlast;
         end
      end
   end

   assign o_cell_wr_en   = wr_en_q;
   assign o_cell_wr_data = wr_data_q;
   assign o_rec_count    = count_q;
   assign o_init_done    = done_q;
   assign o_bad_dest     = bad_q;

endmodule

// File: tb/tb_md_init_scatter.sv
module tb_md_init_scatter;

   logic         ap_clk = 1'b0;
   logic         ap_rst;
   logic         i_init_en;
   logic [26:0]  i_cell_ready;
   logic [26:0]  o_cell_wr_en;
   logic [95:0]  o_cell_wr_data;
   logic [31:0]  o_rec_count;
   logic         o_init_done;
   logic         o_bad_dest;

   int n_cmp = 0;
   int n_err = 0;

   md_init_scatter_if #(.AXIS_TDATA_WIDTH(512), .STREAMING_TDEST_WIDTH(16)) h2k ();

   md_init_scatter #(
      .AXIS_TDATA_WIDTH(512), .STREAMING_TDEST_WIDTH(16), .REC_WIDTH(97),
      .N_SLOT(5), .N_CELL(27)
   ) dut (
      .ap_clk         (ap_clk),
      .ap_rst         (ap_rst),
      .i_init_en      (i_init_en),
      .S_AXIS_h2k     (h2k),
      .o_cell_wr_en   (o_cell_wr_en),
      .o_cell_wr_data (o_cell_wr_data),
      .i_cell_ready   (i_cell_ready),
      .o_rec_count    (o_rec_count),
      .o_init_done    (o_init_done),
      .o_bad_dest     (o_bad_dest)
   );

   always #5 ap_clk = ~ap_clk;

   // Position of slot k: x = base+16k, y = x+1, z = x+2.
   function automatic logic [95:0] pos(input int base, input int k);
      logic [31:0] x;
      x = 32'(base + 16 * k);
      return {x + 32'd2, x + 32'd1, x};
   endfunction

   function automatic logic [511:0] beat(input int base, input logic [4:0] mask);
      logic [511:0] b;
      b = '0;
      b[511:485] = '1;
      for (int k = 0; k < 5; k++) b[97*k +: 97] = {mask[k], pos(base, k)};
      return b;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   // Presents one beat and returns just after the accepting edge.
   task automatic send(input logic [15:0] dest, input logic [511:0] data, input logic last);
      int w;
      h2k.tdata  = data;
      h2k.tkeep  = '1;
      h2k.tdest  = dest;
      h2k.tlast  = last;
      h2k.tvalid = 1'b1;
      #1;
      w = 0;
      while (!h2k.tready && w < 20) begin
         step();
         w++;
      end
      chk("send_tready", h2k.tready, 1'b1);
      step();
      h2k.tvalid = 1'b0;
      h2k.tlast  = 1'b0;
   endtask

   initial begin
      ap_rst       = 1'b1;
      i_init_en    = 1'b0;
      i_cell_ready = '1;
      h2k.tvalid   = 1'b0;
      h2k.tdata    = '0;
      h2k.tkeep    = '0;
      h2k.tdest    = '0;
      h2k.tlast    = 1'b0;
      step();
      step();
      chk("rst_tready", h2k.tready, 1'b0);
      chk("rst_wr_en", o_cell_wr_en, 27'h0);
      chk("rst_wr_data", o_cell_wr_data, 96'h0);
      chk("rst_count", o_rec_count, 32'd0);
      chk("rst_done", o_init_done, 1'b0);
      chk("rst_bad", o_bad_dest, 1'b0);
      ap_rst = 1'b0;
      step();
      i_init_en = 1'b1;
      #1;
      chk("idle_tready", h2k.tready, 1'b1);
      step();

      // All five slots to cell 3.
      send(16'd3, beat(32'h100, 5'b11111), 1'b0);
      chk("t1_unpack_tready", h2k.tready, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t1_wr_en", o_cell_wr_en, 27'h8);
         chk("t1_wr_data", o_cell_wr_data, pos(32'h100, k));
      end
      chk("t1_count", o_rec_count, 32'd5);
      chk("t1_back_idle", h2k.tready, 1'b1);
      step();
      chk("t1_wr_en_off", o_cell_wr_en, 27'h0);

      // Slots 1 and 3 absent: writes only for 0, 2, 4, still five cycles.
      send(16'd3, beat(32'h200, 5'b10101), 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_wr_en", o_cell_wr_en, (k % 2 == 0) ? 27'h8 : 27'h0);
         if (k % 2 == 0) chk("t2_wr_data", o_cell_wr_data, pos(32'h200, k));
      end
      chk("t2_idle_after_5", h2k.tready, 1'b1);
      chk("t2_count", o_rec_count, 32'd8);

      // Cache 3 not ready for four cycles at slot 2.
      send(16'd3, beat(32'h300, 5'b11111), 1'b0);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("t3_pre_data", o_cell_wr_data, pos(32'h300, k));
      end
      i_cell_ready[3] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("t3_stall_wr_en", o_cell_wr_en, 27'h0);
      end
      i_cell_ready = '1;
      for (int k = 2; k < 5; k++) begin
         step();
         chk("t3_post_wr_en", o_cell_wr_en, 27'h8);
         chk("t3_post_data", o_cell_wr_data, pos(32'h300, k));
      end
      chk("t3_count", o_rec_count, 32'd13);

      // Out-of-range destination is swallowed and flagged.
      send(16'd27, beat(32'h400, 5'b11111), 1'b0);
      chk("t4_bad", o_bad_dest, 1'b1);
      chk("t4_stay_idle", h2k.tready, 1'b1);
      chk("t4_no_write", o_cell_wr_en, 27'h0);
      send(16'd0, beat(32'h500, 5'b00001), 1'b0);
      step();
      chk("t4_cell0_wr_en", o_cell_wr_en, 27'h1);
      chk("t4_cell0_data", o_cell_wr_data, pos(32'h500, 0));
      for (int c = 0; c < 4; c++) step();
      chk("t4_count", o_rec_count, 32'd14);
      chk("t4_bad_sticky", o_bad_dest, 1'b1);

      // Re-raise clears; three beats with tlast on the third.
      i_init_en = 1'b0;
      step();
      i_init_en = 1'b1;
      step();
      chk("t5_count_clr", o_rec_count, 32'd0);
      chk("t5_bad_clr", o_bad_dest, 1'b0);
      for (int b = 0; b < 3; b++) begin
         send(16'd5, beat(32'h1000 * (b + 1), 5'b11111), b == 2);
         for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_wr_en", o_cell_wr_en, 27'h20);
            chk("t5_no_early_done", o_init_done, 1'b0);
         end
      end
      chk("t5_last_data", o_cell_wr_data, pos(32'h3000, 4));
      chk("t5_count", o_rec_count, 32'd15);
      chk("t5_in_done", h2k.tready, 1'b0);
      step();
      chk("t5_done_pulse", o_init_done, 1'b1);
      step();
      chk("t5_done_off", o_init_done, 1'b0);
      chk("t5_idle", h2k.tready, 1'b1);

      // Abort at slot 2.
      send(16'd3, beat(32'h600, 5'b11111), 1'b0);
      step();
      step();
      chk("t6_pre_count", o_rec_count, 32'd17);
      i_init_en = 1'b0;
      step();
      chk("t6_abort_wr_en", o_cell_wr_en, 27'h0);
      chk("t6_abort_tready", h2k.tready, 1'b0);
      step();
      chk("t6_no_done", o_init_done, 1'b0);
      chk("t6_count_hold", o_rec_count, 32'd17);
      chk("t6_wr_en_quiet", o_cell_wr_en, 27'h0);
      i_init_en = 1'b1;
      step();
      chk("t6_reraise_count", o_rec_count, 32'd0);
      chk("t6_reraise_tready", h2k.tready, 1'b1);

      // Asynchronous reset mid-beat.
      send(16'd3, beat(32'h700, 5'b11111), 1'b0);
      step();
      step();
      chk("t7_pre_count", o_rec_count, 32'd2);
      #2;
      ap_rst = 1'b1;
      #1;
      chk("t7_rst_wr_en", o_cell_wr_en, 27'h0);
      chk("t7_rst_count", o_rec_count, 32'd0);
      chk("t7_rst_data", o_cell_wr_data, 96'h0);
      step();
      ap_rst = 1'b0;
      step();
      chk("t7_beat_lost", o_cell_wr_en, 27'h0);
      chk("t7_idle", h2k.tready, 1'b1);
      step();
      chk("t7_still_quiet", o_cell_wr_en, 27'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
